multicycle_rv32_core: RTL
=========================

# multicycle_rv32_core

Parametrised multi-cycle RV32I-subset core that replaces the single-cycle CPU top. It reuses one register file and ALU across several cycles under a state machine. Instruction fetch and data access share one memory port with a valid/ready handshake, so wait-state memories and a shared bus can sit behind it. It sits directly under the SoC top level, which is the only place memory is attached.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- ADDR_W, 32, width of mem_addr; the upper PC/ALU bits above ADDR_W are dropped.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store, 0 = load/fetch; valid only while mem_req=1.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  store data (rs2).
- mem_ready  in  1  transfer completes on the edge where mem_req && mem_ready.
- mem_rdata  in  32  read data; sampled on the completing edge.
- pc  out  32  address of the instruction currently executing.
- instr  out  32  latched instruction register (IR).
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- halted  out  1  core stopped by EBREAK or a trap.
- trap  out  1  stop cause is an illegal opcode or a misaligned fetch target; 0 for EBREAK.

## Operation
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, SLT.
  - I-type: ADDI, ANDI, ORI, SLTI.
  - Memory: LW, SW.
  - Branches: BEQ, BNE.
  - Jumps and upper immediate: JAL, JALR, LUI.
  - EBREAK.
- Any other opcode or funct3 enters HALT with trap=1.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On handshake, IR<=mem_rdata and go to DECODE; otherwise stay.
  - DECODE: A<=rs1, B<=rs2, IMM<=sign-extended immediate. EBREAK goes to HALT (trap=0). Illegal opcode goes to HALT (trap=1). All others go to EXEC.
  - EXEC (ALU, LUI): ALUOut<=result; go to WB.
  - EXEC (LW, SW): ALUOut<=A+IMM; go to MEM.
  - EXEC (BEQ, BNE): if taken, PC<=PC+IMM, else PC<=PC+4. Pulse retire and go to FETCH.
  - EXEC (JAL): rd<=PC+4, PC<=PC+IMM. Pulse retire and go to FETCH.
  - EXEC (JALR): rd<=PC+4, PC<=(A+IMM)&~1. Pulse retire and go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(SW), mem_wdata=B. Stay until handshake.
    - SW: on handshake, PC<=PC+4, pulse retire, go to FETCH.
    - LW: on handshake, MDR<=mem_rdata, go to WB.
  - WB: rd<=ALUOut (or MDR for LW), PC<=PC+4, pulse retire, go to FETCH.
  - HALT: absorbing until reset; mem_req=0, retire=0.
- Branch and jump targets are relative to the instruction's own PC, not PC+4.
- A new PC with bits [1:0] != 0 does not update PC; the core goes to HALT with trap=1 and retire=0.
- Writes to x0 are discarded; x0 always reads 0.
- SLT and SLTI use a signed compare. All arithmetic is 32-bit with wrap-around and no overflow trap.
- Reset values: PC=RESET_PC, state=FETCH, IR=0, all registers x1..x31=0.
  - Outputs after reset: mem_req=1 (FETCH is entered immediately), mem_we=0, retire=0, halted=0, trap=0.
- Reset asserted mid-transaction clears mem_req combinationally with state. The memory side must tolerate an abandoned request.

## Timing
- Cycle counts with mem_ready held at 1:
  - BEQ, BNE, JAL, JALR: 3 cycles.
  - ALU, LUI, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle that mem_ready=0 during FETCH or MEM adds one cycle. mem_addr, mem_we and mem_wdata stay stable while waiting.
- mem_req never drops without a handshake, except on reset or HALT entry from DECODE.
- retire is high for exactly one cycle per instruction, coincident with the edge that commits PC.
- A register written by instruction N is visible to instruction N+1's DECODE; no bypass is needed.

## Test plan
- Reset to RESET_PC=0x100, mem_ready=1 -> first mem_addr=0x100, mem_req=1 during reset release; pc=0x100.
- Program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SLT x4,x2,x1 -> x3=2, x4=1; 4 retires in 16 cycles.
- SW x3,8(x0) then LW x5,8(x0), with mem_ready low for 2 cycles on each access -> store of 2 at address 8 with mem_we=1; x5=2; LW takes 7 cycles.
- BEQ x1,x1,-8 at PC 0x20 -> next fetch at 0x18. BNE taken to 0x22 -> halted=1, trap=1, no retire.
- JAL x1,+16 at 0x40 -> x1=0x44, fetch 0x50. JALR x0,0(x1) -> fetch 0x44. Write to x0 leaves x0=0.
- EBREAK -> halted=1, trap=0, mem_req stays 0. Undefined opcode 0x7F -> trap=1. rst pulse mid-MEM wait -> mem_req=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/multicycle_rv32_core.sv
// rtl/multicycle_rv32_core.sv - multi-cycle RV32I-subset core with one shared memory port
//
// Purpose: executes ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI/SLTI, LW/SW, BEQ/BNE,
//   JAL/JALR, LUI and EBREAK. One state machine reuses a single register
//   file and ALU. Fetch and data access share one valid/ready memory port.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   mem_req/mem_we   request valid and store select (store only in MEM)
//   mem_addr         word-aligned byte address (PC or ALUOut)
//   mem_wdata        store data (rs2)
//   mem_ready        a transfer completes on an edge where mem_req && mem_ready
//   mem_rdata        read data, sampled on the completing edge
//   pc, instr        PC of the executing instruction and its latched IR
//   retire           one-cycle pulse on the edge that commits PC
//   halted, trap     stopped; trap=1 for an illegal or misaligned-target stop
module multicycle_rv32_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              retire,
  output logic              halted,
  output logic              trap
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        trap_q, trap_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_ebreak, legal;
  logic [31:0] imm_dec;
  always_comb begin
    is_r      = (opcode == OP_R) && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111})
                && ((funct7 == 7'h00) || ((funct7 == 7'h20) && (funct3 == 3'b000)));
    is_i      = (opcode == OP_I) && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
    is_lw     = (opcode == OP_LW) && (funct3 == 3'b010);
    is_sw     = (opcode == OP_SW) && (funct3 == 3'b010);
    is_br     = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
    is_lui    = (opcode == OP_LUI);
    is_ebreak = (ir_q == EBREAK);
    legal     = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;
    imm_dec   = {{20{ir_q[31]}}, ir_q[31:20]};
    if (is_sw)       imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_br)  imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else if (is_jal) imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    else if (is_lui) imm_dec = {ir_q[31:12], 12'd0};
  end

  logic [31:0] op_b, sum, alu_res, pc_plus4, target;
  logic        taken, misaligned;
  always_comb begin
    op_b = is_r ? b_q : imm_q;
    sum  = a_q + op_b;
    case (funct3)
      3'b000:  alu_res = (is_r && funct7[5]) ? (a_q - op_b) : sum;
      3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(op_b)};
      3'b110:  alu_res = a_q | op_b;
      3'b111:  alu_res = a_q & op_b;
      default: alu_res = sum;
    endcase
    // LW/SW share funct3=010 with SLT, so force the address add here.
    if (is_lui)              alu_res = imm_q;
    else if (is_lw || is_sw) alu_res = sum;
    pc_plus4 = pc_q + 32'd4;
    taken    = funct3[0] ? (a_q != b_q) : (a_q == b_q);
    if (is_jalr)                         target = sum & ~32'd1;
    else if (is_jal || (is_br && taken)) target = pc_q + imm_q;
    else                                 target = pc_plus4;
    misaligned = (target[1:0] != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_wdata = 32'd0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_q[rs1];
        b_d   = rf_q[rs2];
        imm_d = imm_dec;
        if (is_ebreak)  state_d = S_HALT;
        else if (!legal) begin
          state_d = S_HALT;
          trap_d  = 1'b1;
        end else state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_d   = alu_res;
          state_d = S_MEM;
        end else if (is_r || is_i || is_lui) begin
          alu_d   = alu_res;
          state_d = S_WB;
        end else if (misaligned) begin
          // Control transfer to a misaligned target: PC and rd stay untouched.
          state_d = S_HALT;
          trap_d  = 1'b1;
        end else begin
          pc_d     = target;
          rf_we    = is_jal | is_jalr;
          rf_wdata = pc_plus4;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM: if (mem_ready) begin
        if (is_sw) begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = is_lw ? mdr_q : alu_q;
        pc_d     = pc_plus4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        trap_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      trap_q  <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
      // x0 is never written, so it keeps its reset value of zero.
      if (rf_we && (rd != 5'd0)) rf_q[rd] <= rf_wdata;
    end
  end

  // rst gates the request directly so an in-flight access is abandoned at once.
  logic [31:0] addr_full;
  assign addr_full = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_req   = ~rst & ((state_q == S_FETCH) | (state_q == S_MEM));
  assign mem_we    = mem_req & (state_q == S_MEM) & is_sw;
  assign mem_addr  = addr_full[ADDR_W-1:0] & ~ADDR_W'(3);
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign halted    = (state_q == S_HALT);
  assign trap      = trap_q;

endmodule
